// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Applies hazard-unit flush/stall as bubbles and counts them in saturating counters.
module id_ex_pipeline_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      validD,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [DATA_WIDTH-1:0]     PCPlus4D,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic                      RegWriteD,
  input  logic                      MemWriteD,
  input  logic                      MemReadD,
  input  logic                      BranchD,
  input  logic                      JumpD,
  input  logic                      ALUSrcD,
  input  logic [1:0]                ResultSrcD,
  input  logic [ALU_CTRL_WIDTH-1:0] ALUControlD,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [DATA_WIDTH-1:0]     PCPlus4E,
  output logic [DATA_WIDTH-1:0]     RD1E,
  output logic [DATA_WIDTH-1:0]     RD2E,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      RegWriteE,
  output logic                      MemWriteE,
  output logic                      MemReadE,
  output logic                      BranchE,
  output logic                      JumpE,
  output logic                      ALUSrcE,
  output logic [1:0]                ResultSrcE,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControlE,
  output logic                      validE,
  output logic [CNT_WIDTH-1:0]      bubble_count,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic load_bubble;
  assign load_bubble = rst | flush | stall;

  // A bubble zeroes every field, so Rs/Rd=x0 keeps the hazard unit from matching it.
  always_ff @(posedge clk) begin
    if (load_bubble) begin
      PCE         <= '0;
      PCPlus4E    <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      MemReadE    <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      validE      <= 1'b0;
    end else begin
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      ImmExtE     <= ImmExtD;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      // Invalid instructions still carry data, but can have no side effects.
      RdE         <= validD ? RdD : '0;
      RegWriteE   <= validD & RegWriteD;
      MemWriteE   <= validD & MemWriteD;
      MemReadE    <= validD & MemReadD;
      BranchE     <= validD & BranchD;
      JumpE       <= validD & JumpD;
      ALUSrcE     <= validD & ALUSrcD;
      ResultSrcE  <= validD ? ResultSrcD : '0;
      ALUControlE <= validD ? ALUControlD : '0;
      validE      <= validD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count <= '0;
      flush_count  <= '0;
    end else if (flush) begin
      if (flush_count != CNT_MAX) flush_count <= flush_count + CNT_ONE;
    end else if (stall) begin
      if (bubble_count != CNT_MAX) bubble_count <= bubble_count + CNT_ONE;
    end
  end

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
- Decode-to-execute (ID/EX) pipeline register of the 5-stage RV32I core.
- Consumes the hazard unit's stall and flush outputs and applies them to the execute stage:
  - stall inserts a bubble for a load-use hazard.
  - flush squashes the wrong-path instruction after a taken branch or jump.
- Supplies the execute-stage register indices and control bits back to the hazard unit.
- Keeps saturating bubble/flush counters for performance analysis.

Parameters:
- DATA_WIDTH, 32, width of PC, operand and immediate fields
- REG_ADDR_WIDTH, 5, register index width
- ALU_CTRL_WIDTH, 4, ALU control field width
- CNT_WIDTH, 16, width of each performance counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit load-use stall; insert bubble into E
- flush  in  1  hazard unit branch flush; squash E
- validD  in  1  decode stage holds a real instruction
- PCD, PCPlus4D, RD1D, RD2D, ImmExtD  in  DATA_WIDTH each  decode datapath fields
- Rs1D, Rs2D, RdD  in  REG_ADDR_WIDTH each  decode register indices
- RegWriteD, MemWriteD, MemReadD, BranchD, JumpD, ALUSrcD  in  1 each  decode control bits
- ResultSrcD  in  2  result mux select
- ALUControlD  in  ALU_CTRL_WIDTH  ALU operation
- PCE, PCPlus4E, RD1E, RD2E, ImmExtE  out  DATA_WIDTH each  registered datapath fields
- Rs1E, Rs2E, RdE  out  REG_ADDR_WIDTH each  registered indices (to hazard unit)
- RegWriteE, MemWriteE, MemReadE, BranchE, JumpE, ALUSrcE  out  1 each  registered control
- ResultSrcE  out  2; ALUControlE  out  ALU_CTRL_WIDTH
- validE  out  1  execute stage holds a real instruction
- bubble_count  out  CNT_WIDTH  cycles a stall bubble was inserted
- flush_count  out  CNT_WIDTH  cycles a flush squashed E

Behaviour:
- All state updates on the rising edge of clk. rst is synchronous, active-high.
- Reset:
  - All outputs, both counters and validE go to 0.
  - The stage therefore holds a bubble with RdE=0 and RegWriteE=MemReadE=MemWriteE=BranchE=JumpE=0.
- Each edge takes exactly one action, in priority order rst > flush > stall > load:
  - flush=1: load a bubble. flush_count increments. bubble_count is unchanged, even if stall=1 in the same cycle.
  - flush=0, stall=1: load a bubble. bubble_count increments.
  - Neither asserted: capture all D fields into E fields with one cycle of latency. validE takes validD.
- Bubble contents:
  - Every output field is 0, including data fields, Rs1E, Rs2E, RdE and validE.
  - Rs/Rd=0 means the hazard unit never forwards from, or stalls on, a bubble, because x0 is never matched.
- Invalid capture: on a load with validD=0:
  - Control bits and RdE are forced to 0 and validE=0.
  - Data fields and Rs1E/Rs2E are still captured.
  - Neither counter changes.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap. They clear only on rst.
- rst asserted alongside flush/stall: reset wins and counters clear that cycle.
- No combinational path from any input to any output; all outputs are registered.
- This block does not hold its contents on stall.
  - Freezing F/D is the job of the upstream registers.
  - E always advances, to either a bubble or a new instruction.

Test Plan:
- Reset: drive rst=1 for 2 cycles with validD=1, RdD=5, RegWriteD=1 -> after the edge RdE=0, RegWriteE=0, validE=0, both counters=0.
- Normal flow: release rst, PCD=0x100, RdD=7, RegWriteD=1, ALUControlD=4'h3 -> next edge PCE=0x100, RdE=7, RegWriteE=1, ALUControlE=3, validE=1, counters unchanged.
- Load-use stall: stall=1 for one cycle with RdD=9, MemReadD=1 -> RdE=0, MemReadE=0, validE=0, bubble_count=1. The next unstalled edge captures the D fields normally.
- Flush priority: stall=1 and flush=1 together for 3 cycles -> E is a bubble each cycle, flush_count=3, bubble_count=0.
- Invalid D: validD=0, RdD=12, RegWriteD=1, RD1D=0xDEAD -> RdE=0, RegWriteE=0, RD1D value 0xDEAD on RD1E, validE=0, no counter change.
- Saturation: use CNT_WIDTH=4 and hold stall=1 for 20 cycles -> bubble_count reaches 15 and stays there. Then rst=1 for one cycle -> bubble_count=0.
